data_stack: RTL and testbench

DATA_STACK -- requirements
Module: data_stack

---
 rtl/data_stack_pkg.sv | 26 ++
 rtl/stack_ram.sv | 23 ++
 rtl/data_stack.sv | 125 ++++++++++++
 tb/tb_data_stack.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared processor constants: data-stack operation codes and ALU opcodes.
package data_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_BINOP = 3'b011,
    OP_REPL  = 3'b100,
    OP_DUP   = 3'b101,
    OP_SWAP  = 3'b110,
    OP_NOP7  = 3'b111
  } stack_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_e;

endpackage

// File: rtl/stack_ram.sv
// Spill register file for the data stack: synchronous write, asynchronous read.
module stack_ram #(
  parameter int WIDTH   = 16,
  parameter int ENTRIES = 14,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Operand stack with Top/Next held in registers and deeper entries spilled to stack_ram.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               Op,
  input  logic [WIDTH-1:0]         Din,
  output logic [WIDTH-1:0]         Top,
  output logic [WIDTH-1:0]         Next,
  output logic [$clog2(DEPTH):0]   Depth,
  output logic                     Empty,
  output logic                     Full,
  output logic                     Err
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH - 2);

  logic [WIDTH-1:0] top_r, next_r, top_d, next_d, rd;
  logic [DW-1:0]    depth_r, depth_d;
  logic             empty_r, full_r, err_r;
  logic             rej, we, has1, has2, has3;
  logic [AW-1:0]    waddr, raddr;

  // Spill slot i holds the i-th entry from the bottom, so pushes never move data.
  assign waddr = AW'(depth_r - DW'(2));
  assign raddr = AW'(depth_r - DW'(3));
  assign has1  = depth_r != '0;
  assign has2  = depth_r >= DW'(2);
  assign has3  = depth_r >= DW'(3);

  stack_ram #(.WIDTH(WIDTH), .ENTRIES(DEPTH - 2), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (next_r),
    .raddr (raddr),
    .rdata (rd)
  );

  always_comb begin
    top_d   = top_r;
    next_d  = next_r;
    depth_d = depth_r;
    rej     = 1'b0;
    we      = 1'b0;
    case (stack_op_e'(Op))
      OP_PUSH: begin
        if (full_r) rej = 1'b1;
        else begin
          top_d   = Din;
          next_d  = top_r;
          we      = has2;
          depth_d = depth_r + DW'(1);
        end
      end
      OP_POP: begin
        if (!has1) rej = 1'b1;
        else begin
          top_d   = next_r;
          next_d  = has3 ? rd : '0;
          depth_d = depth_r - DW'(1);
        end
      end
      OP_BINOP: begin
        if (!has2) rej = 1'b1;
        else begin
          top_d   = Din;
          next_d  = has3 ? rd : '0;
          depth_d = depth_r - DW'(1);
        end
      end
      OP_REPL: begin
        if (!has1) rej = 1'b1;
        else top_d = Din;
      end
      OP_DUP: begin
        if (full_r || !has1) rej = 1'b1;
        else begin
          next_d  = top_r;
          we      = has2;
          depth_d = depth_r + DW'(1);
        end
      end
      OP_SWAP: begin
        if (!has2) rej = 1'b1;
        else begin
          top_d  = next_r;
          next_d = top_r;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_r   <= '0;
      next_r  <= '0;
      depth_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      top_r   <= top_d;
      next_r  <= next_d;
      depth_r <= depth_d;
      empty_r <= depth_d == '0;
      full_r  <= depth_d == DW'(DEPTH);
      err_r   <= rej;
    end
  end

  assign Top   = top_r;
  assign Next  = next_r;
  assign Depth = depth_r;
  assign Empty = empty_r;
  assign Full  = full_r;
  assign Err   = err_r;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboarded bench for data_stack: directed scenarios plus random ops against a queue model.
module tb_data_stack;
  import data_stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       Op;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Top, Next;
  logic [4:0]       Depth;
  logic             Empty, Full, Err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [4:0]       depth;
    logic             empty;
    logic             full;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] mdl[$];

  data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Din(Din),
    .Top(Top), .Next(Next), .Depth(Depth),
    .Empty(Empty), .Full(Full), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t snap(input logic err);
    exp_t e;
    int   n = mdl.size();
    e.top   = (n > 0) ? mdl[n-1] : '0;
    e.next  = (n > 1) ? mdl[n-2] : '0;
    e.depth = 5'(n);
    e.empty = (n == 0);
    e.full  = (n == DEPTH);
    e.err   = err;
    return e;
  endfunction

  // Reference model: stack as a queue with its top at the back.
  function automatic logic model_step(input logic [2:0] op, input logic [WIDTH-1:0] d);
    int n = mdl.size();
    logic [WIDTH-1:0] a, b;
    case (op)
      3'b001: begin if (n == DEPTH) return 1'b1; mdl.push_back(d); end
      3'b010: begin if (n < 1) return 1'b1; void'(mdl.pop_back()); end
      3'b011: begin if (n < 2) return 1'b1; void'(mdl.pop_back()); void'(mdl.pop_back()); mdl.push_back(d); end
      3'b100: begin if (n < 1) return 1'b1; mdl[n-1] = d; end
      3'b101: begin if (n < 1 || n == DEPTH) return 1'b1; mdl.push_back(mdl[n-1]); end
      3'b110: begin if (n < 2) return 1'b1; a = mdl[n-1]; b = mdl[n-2]; mdl[n-1] = b; mdl[n-2] = a; end
      default: ;
    endcase
    return 1'b0;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("top",   Top,   e.top);
    chk("next",  Next,  e.next);
    chk("depth", Depth, e.depth);
    chk("empty", Empty, e.empty);
    chk("full",  Full,  e.full);
    chk("err",   Err,   e.err);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] d);
    logic r;
    Op  = op;
    Din = d;
    r   = model_step(op, d);
    sb.push_back(snap(r));
    @(posedge clk); #1;
    compare_out();
  endtask

  task automatic do_reset(input logic [2:0] op);
    reset = 1'b1;
    Op    = op;
    Din   = 16'h1234;
    mdl.delete();
    sb.push_back(snap(1'b0));
    @(posedge clk); #1;
    compare_out();
    reset = 1'b0;
    Op    = OP_NOP;
  endtask

  initial begin
    reset = 1'b1;
    Op    = OP_NOP;
    Din   = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(OP_NOP);
    chk("rst_top", Top, 0);
    chk("rst_empty", Empty, 1);

    // push / pop
    do_op(OP_PUSH, 16'h0005);
    do_op(OP_PUSH, 16'h0003);
    chk("pp_top", Top, 16'h3); chk("pp_next", Next, 16'h5); chk("pp_depth", Depth, 2);
    do_op(OP_POP, 0);
    chk("pop_top", Top, 16'h5); chk("pop_next", Next, 0); chk("pop_depth", Depth, 1);

    // ALU loop
    do_reset(OP_NOP);
    do_op(OP_PUSH, 16'h0005);
    do_op(OP_PUSH, 16'h0003);
    do_op(OP_BINOP, 16'h0008);
    chk("alu_top", Top, 16'h8); chk("alu_depth", Depth, 1); chk("alu_err", Err, 0);

    // overflow, then BINOP while full
    do_reset(OP_NOP);
    for (int i = 1; i <= DEPTH; i++) do_op(OP_PUSH, 16'(i));
    chk("ovf_full", Full, 1);
    do_op(OP_PUSH, 16'hFFFF);
    chk("ovf_err", Err, 1); chk("ovf_top", Top, 16); chk("ovf_depth", Depth, 16);
    do_op(OP_BINOP, 16'h0020);
    chk("ovf_err_once", Err, 0); chk("fb_depth", Depth, 15); chk("fb_top", Top, 16'h20);
    chk("fb_next", Next, 14); chk("fb_full", Full, 0);

    // underflow
    do_reset(OP_NOP);
    do_op(OP_PUSH, 16'h0007);
    do_op(OP_SWAP, 0);  chk("uf_swap_err", Err, 1);
    do_op(OP_BINOP, 0); chk("uf_binop_err", Err, 1);
    do_op(OP_POP, 0);   chk("uf_pop_ok", Err, 0);
    do_op(OP_POP, 0);   chk("uf_pop_err", Err, 1);
    chk("uf_depth", Depth, 0); chk("uf_empty", Empty, 1);

    // spill integrity
    do_reset(OP_NOP);
    for (int v = 'hA; v <= 'hF; v++) do_op(OP_PUSH, 16'(v));
    do_op(OP_SWAP, 0);
    do_op(OP_DUP, 0);
    begin
      logic [WIDTH-1:0] seq [7] = '{16'hE, 16'hF, 16'hD, 16'hC, 16'hB, 16'hA, 16'h0};
      for (int i = 0; i < 7; i++) begin
        do_op(OP_POP, 0);
        chk($sformatf("spill_pop%0d", i), Top, seq[i]);
      end
    end

    // reset overrides a PUSH mid-sequence
    for (int i = 0; i < 5; i++) do_op(OP_PUSH, 16'(100 + i));
    chk("pre_rst_depth", Depth, 5);
    do_reset(OP_PUSH);
    chk("mid_rst_depth", Depth, 0); chk("mid_rst_top", Top, 0); chk("mid_rst_err", Err, 0);

    // random traffic, biased toward pushes so the spill area is exercised
    for (int i = 0; i < 600; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 3) == 0) ? OP_PUSH : 3'($urandom_range(0, 7));
      do_op(op, 16'($urandom));
    end

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
